// File: rtl/dpram_pkg.sv
// Shared sizing for the dual-port-RAM FIFO controller: default widths,
// RAM depth and pointer width.
package dpram_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    localparam int DEPTH     = depth_of(ADDR_WIDTH_DEF);
    localparam int PTR_WIDTH = ADDR_WIDTH_DEF + 1;

endpackage

// File: rtl/dpram_fifo_obuf.sv
// Two-entry output buffer sitting behind the RAM read port; head is the
// oldest word and is always presented as registered read data.
module dpram_fifo_obuf
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  cap,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  pop,
    output logic [1:0]            cnt,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] tail;

    // The read scheduler never captures into a full buffer without a pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            case ({cap, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= cap_data;
                    else             tail <= cap_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= cap_data;
                    end else begin
                        head <= tail;
                        tail <= cap_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller wrapping an external dual-port RAM with one-cycle read
// latency; owns the pointers, full/empty logic and both RAM ports.
module dpram_fifo_ctrl
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int LW = ADDR_WIDTH + 2;
    localparam logic [PW-1:0] RAM_DEPTH = PW'(depth_of(ADDR_WIDTH));

    logic [PW-1:0] wr_ptr, rd_ptr, ram_used;
    logic          inflight;
    logic [1:0]    obuf_cnt;
    logic          wr_fire, pop;
    logic [2:0]    occ_after_pop;

    // Valid/ready: a word moves on a posedge where valid and ready are both
    // high; valid never waits on ready, ready depends only on state and flush.
    assign ram_used = wr_ptr - rd_ptr;
    assign s_ready  = (ram_used < RAM_DEPTH) && !flush;
    assign wr_fire  = s_valid && s_ready;
    assign wr_en    = wr_fire;
    assign wr_addr  = wr_ptr[ADDR_WIDTH-1:0];
    assign wr_data  = wr_fire ? s_data : '0;

    // ram_used excludes this cycle's write, so a word is never read as it lands.
    assign pop           = m_valid && m_ready;
    assign occ_after_pop = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd_en         = (ram_used != '0) && (occ_after_pop < 3'd2) && !flush;
    assign rd_addr       = rd_ptr[ADDR_WIDTH-1:0];

    assign m_valid = (obuf_cnt != 2'd0);
    assign level   = LW'(ram_used) + LW'(inflight) + LW'(obuf_cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en)   rd_ptr <= rd_ptr + PW'(1);
            inflight <= rd_en;
        end
    end

    dpram_fifo_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .cap     (inflight),
        .cap_data(rd_data),
        .pop     (pop),
        .cnt     (obuf_cnt),
        .head    (m_data)
    );

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural RAM with one-cycle read latency,
// a cycle-vector table and directed multi-cycle sequences.
module tb_dpram_fifo_ctrl;

    logic       clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic       s_valid = 1'b0, m_ready = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, m_valid, wr_en, rd_en;
    logic [7:0] m_data, wr_data, rd_data;
    logic [5:0] level;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] mem [16];

    int checks = 0, failures = 0, rx_cnt = 0, tx_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic f; logic sv; logic [7:0] sd; logic mr;
        logic e_srdy; logic e_mv; logic [7:0] e_md; logic [5:0] e_lvl;
        logic e_we; logic [3:0] e_wa; logic e_re; logic [3:0] e_ra;
    } vec_t;
    vec_t tbl[11];

    dpram_fifo_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 1);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_level"},   32'(level),   0);
        check({tag, "_wr_en"},   32'(wr_en),   0);
        check({tag, "_rd_en"},   32'(rd_en),   0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
        check({tag, "_m_data"},  32'(m_data),  0);
    endtask

    // One cycle: drive at negedge, sample 1ns later, update the scoreboard.
    task automatic step(input logic f, input logic sv, input logic [7:0] sd, input logic mr);
        @(negedge clk);
        flush = f; s_valid = sv; s_data = sd; m_ready = mr;
        #1;
        check("level_vs_model", 32'(level), 32'(exp_q.size()));
        if (m_valid && m_ready) begin
            rx_cnt++;
            check("pop_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
        end
        if (s_valid && s_ready) begin
            exp_q.push_back(s_data);
            tx_cnt++;
        end
        if (f) exp_q.delete();
    endtask

    initial begin
        int sent, wraps, bubbles, rx0, tx0, r0, t0;
        logic started;

        //           f     sv    sd     mr    srdy  mv    md     lvl    we    wa     re    ra
        tbl[0]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b1, 4'd0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd1, 1'b0, 4'd1, 1'b1, 4'd0};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd1, 1'b0, 4'd1, 1'b0, 4'd1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 6'd1, 1'b0, 4'd1, 1'b0, 4'd1};
        tbl[4]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 8'hA5, 6'd1, 1'b1, 4'd1, 1'b0, 4'd1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd1, 1'b0, 4'd2, 1'b1, 4'd1};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 6'd1, 1'b0, 4'd2, 1'b0, 4'd2};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 6'd1, 1'b0, 4'd2, 1'b0, 4'd2};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 4'd2, 1'b0, 4'd2};
        tbl[9]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 4'd2, 1'b0, 4'd2};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 4'd0, 1'b0, 4'd0};

        // Clock/reset
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        // Table vectors: first row writes at the first posedge after release.
        for (int i = 0; i < 11; i++) begin
            flush = tbl[i].f; s_valid = tbl[i].sv; s_data = tbl[i].sd; m_ready = tbl[i].mr;
            #1;
            check($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].e_srdy));
            check($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
            if (tbl[i].e_mv) check($sformatf("v%0d_m_data", i), 32'(m_data), 32'(tbl[i].e_md));
            check($sformatf("v%0d_level", i),   32'(level),   32'(tbl[i].e_lvl));
            check($sformatf("v%0d_wr_en", i),   32'(wr_en),   32'(tbl[i].e_we));
            check($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].e_wa));
            if (tbl[i].e_we) check($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(tbl[i].sd));
            check($sformatf("v%0d_rd_en", i),   32'(rd_en),   32'(tbl[i].e_re));
            check($sformatf("v%0d_rd_addr", i), 32'(rd_addr), 32'(tbl[i].e_ra));
            @(negedge clk);
        end
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;

        // Fill to 16, top up to 18, then full-side behaviour and drain.
        tx0 = tx_cnt;
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        check("fill_accept16", 32'(tx_cnt - tx0), 16);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
        check("fill_level16", 32'(level), 16);
        check("fill_m_valid", 32'(m_valid), 1);
        check("fill_head", 32'(m_data), 0);
        step(1'b0, 1'b1, 8'h10, 1'b0);
        step(1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b1, 8'h99, 1'b0);
        check("full_s_ready", 32'(s_ready), 0);
        check("full_wr_en", 32'(wr_en), 0);
        check("full_level18", 32'(level), 18);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("full_level_hold", 32'(level), 18);
        check("full_wr_addr", 32'(wr_addr), 2);
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) step(1'b0, 1'b0, 8'h00, 1'b1);
        check("fill_drained", 32'(exp_q.size()), 0);

        // Flush with a read in flight: stale rd_data must not appear.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("flush_s_ready_during", 32'(s_ready), 0);
        check("flush_rd_en_during", 32'(rd_en), 0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("flush_level", 32'(level), 0);
        check("flush_m_valid", 32'(m_valid), 0);
        check("flush_s_ready", 32'(s_ready), 1);
        r0 = rx_cnt;
        step(1'b0, 1'b1, 8'h77, 1'b0);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (4) step(1'b0, 1'b0, 8'h00, 1'b1);
        check("flush_rx_one", 32'(rx_cnt - r0), 1);

        // Streaming 40 words at full rate from pointer 0.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        sent = 0; wraps = 0; bubbles = 0; rx0 = rx_cnt; started = 1'b0;
        for (int c = 0; c < 200 && (rx_cnt - rx0) < 40; c++) begin
            t0 = tx_cnt; r0 = rx_cnt;
            step(1'b0, 1'(sent < 40), 8'(sent), 1'b1);
            if (tx_cnt != t0) begin
                check("stream_wr_addr", 32'(wr_addr), 32'(sent % 16));
                if (sent > 0 && wr_addr == 4'd0) wraps++;
                sent++;
            end
            if (rx_cnt != r0) started = 1'b1;
            else if (started && (rx_cnt - rx0) < 40) bubbles++;
        end
        check("stream_count", 32'(rx_cnt - rx0), 40);
        check("stream_wraps", 32'(wraps), 2);
        check("stream_bubbles", 32'(bubbles), 0);

        // Random stalls on both sides over 100 words.
        sent = 0; rx0 = rx_cnt;
        for (int c = 0; c < 3000 && (rx_cnt - rx0) < 100; c++) begin
            t0 = tx_cnt;
            step(1'b0, 1'((sent < 100) && ($urandom_range(0, 1) == 1)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            if (tx_cnt != t0) sent++;
        end
        check("rand_count", 32'(rx_cnt - rx0), 100);
        check("rand_empty", 32'(exp_q.size()), 0);

        // Reset pulse at level 7, then the next word must come out first.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("pre_rst_level7", 32'(level), 7);
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0; rst = 1'b0;
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        r0 = rx_cnt;
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
        check("post_rst_rx_one", 32'(rx_cnt - r0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
